instr_sequencer: RTL

//  Multi-cycle sequencer for the 4-bit-opcode datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/seq_pkg.sv | 39 +++
 rtl/instr_sequencer_if.sv | 49 ++++
 rtl/seq_counter.sv | 42 ++++
 rtl/instr_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared state encoding, opcode/function constants and the
//                PC-source select codes for the instruction sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_pkg;

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXEC    = 3'd2,
      MEMWAIT = 3'd3,
      WBACK   = 3'd4,
      STALL   = 3'd5,
      HALT    = 3'd6
   } state_t;

   typedef logic [1:0] pcsel_t;

   localparam logic [3:0] OP_ALU   = 4'b0000;
   localparam logic [3:0] OP_STALL = 4'b0111;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   localparam logic [3:0] FN_FPM = 4'b0010;
   localparam logic [3:0] FN_MUL = 4'b0100;
   localparam logic [3:0] FN_DIV = 4'b0101;

   localparam pcsel_t PCSEL_INC = 2'b00;
   localparam pcsel_t PCSEL_BR  = 2'b01;
   localparam pcsel_t PCSEL_JMP = 2'b10;

   function automatic logic isMultiCycle(input logic [3:0] op, input logic [3:0] fn);
      return (op == OP_ALU) && ((fn == FN_FPM) || (fn == FN_MUL) || (fn == FN_DIV));
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer_if
//  Description : Decode inputs and datapath enables between the control unit,
//                the sequencer and the PC/IR/ALU/memory/regfile blocks.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_sequencer_if;
   import seq_pkg::*;

   logic [3:0]  Opcode;
   logic [3:0]  FunctCode;
   logic        Branch;
   logic        Jump;
   logic        MemRead;
   logic        MemWrite;
   logic        RegWrite;
   logic        BranchTaken;
   logic        AluDone;
   logic        MemReady;
   logic        Resume;
   logic        IRWrite;
   logic        AluStart;
   logic        MemReq;
   logic        RegWriteEn;
   logic        PCWrite;
   pcsel_t      PCSrcSel;
   logic        Halted;
   logic        MemErr;
   logic [15:0] RetireCnt;

   // Sequencer side
   modport master (
      input  Opcode, FunctCode, Branch, Jump, MemRead, MemWrite, RegWrite,
             BranchTaken, AluDone, MemReady, Resume,
      output IRWrite, AluStart, MemReq, RegWriteEn, PCWrite, PCSrcSel,
             Halted, MemErr, RetireCnt
   );

   // Datapath / control-unit side
   modport slave (
      output Opcode, FunctCode, Branch, Jump, MemRead, MemWrite, RegWrite,
             BranchTaken, AluDone, MemReady, Resume,
      input  IRWrite, AluStart, MemReq, RegWriteEn, PCWrite, PCSrcSel,
             Halted, MemErr, RetireCnt
   );

endinterface
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_counter
//  Description : Load/increment/decrement counter with zero flag, shared by
//                the stall countdown and the memory-wait timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_counter #(
   parameter int CNT_W = 4
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_load,
   input  wire logic [CNT_W-1:0] i_loadVal,
   input  wire logic             i_inc,
   input  wire logic             i_dec,
   output logic      [CNT_W-1:0] o_count,
   output logic                  o_zero
);

   localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_count;

   // Load wins over inc, inc over dec
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (i_inc) begin
         r_count <= r_count + c_ONE;
      end else if (i_dec) begin
         r_count <= r_count - c_ONE;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer that holds the
//                PC through ALU waits, memory waits, stalls and halt.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int STALL_CYCLES = 4,
   parameter int MEM_TIMEOUT  = 15,
   parameter int CNT_W        = 4
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   instr_sequencer_if.master bus
);

   localparam logic [CNT_W-1:0] c_STALL_INIT   = CNT_W'(STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic             r_mc;
   logic             w_mcNext;
   logic             r_firstExec;
   pcsel_t           r_pcSel;
   pcsel_t           w_pcSelNow;
   logic             r_memErr;
   logic [15:0]      r_retireCnt;

   logic             w_pcWrite;
   pcsel_t           w_pcSrcSel;
   logic             w_aluStart;
   logic             w_setMemErr;
   logic             w_cntLoad;
   logic [CNT_W-1:0] w_cntLoadVal;
   logic             w_cntInc;
   logic             w_cntDec;
   logic [CNT_W-1:0] w_cntCount;
   logic             w_cntZero;

   seq_counter #(.CNT_W(CNT_W)) u_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_cntLoad),
      .i_loadVal (w_cntLoadVal),
      .i_inc     (w_cntInc),
      .i_dec     (w_cntDec),
      .o_count   (w_cntCount),
      .o_zero    (w_cntZero)
   );

   // Jump outranks a taken branch
   assign w_pcSelNow = bus.Jump                      ? PCSEL_JMP :
                       (bus.Branch & bus.BranchTaken) ? PCSEL_BR  : PCSEL_INC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= FETCH;
         r_mc        <= 1'b0;
         r_firstExec <= 1'b0;
         r_pcSel     <= PCSEL_INC;
         r_memErr    <= 1'b0;
         r_retireCnt <= 16'd0;
      end else begin
         r_state     <= w_nextState;
         r_mc        <= w_mcNext;
         r_firstExec <= (r_state == DECODE) && (w_nextState == EXEC);
         if (r_state == EXEC) begin
            r_pcSel <= w_pcSelNow;
         end
         if (w_setMemErr) begin
            r_memErr <= 1'b1;
         end
         if (w_pcWrite) begin
            r_retireCnt <= r_retireCnt + 16'd1;
         end
      end
   end

   always_comb begin
      w_nextState  = r_state;
      w_mcNext     = r_mc;
      w_pcWrite    = 1'b0;
      w_pcSrcSel   = PCSEL_INC;
      w_aluStart   = 1'b0;
      w_setMemErr  = 1'b0;
      w_cntLoad    = 1'b0;
      w_cntLoadVal = '0;
      w_cntInc     = 1'b0;
      w_cntDec     = 1'b0;

      case (r_state)
         FETCH: begin
            w_nextState = DECODE;
         end
         DECODE: begin
            if (bus.Opcode == OP_HALT) begin
               w_nextState = HALT;
            end else if (bus.Opcode == OP_STALL) begin
               w_nextState  = STALL;
               w_cntLoad    = 1'b1;
               w_cntLoadVal = c_STALL_INIT;
            end else begin
               w_nextState = EXEC;
               w_mcNext    = isMultiCycle(bus.Opcode, bus.FunctCode);
            end
         end
         EXEC: begin
            w_aluStart = r_firstExec & r_mc;
            if (!r_mc || bus.AluDone) begin
               if (bus.MemRead || bus.MemWrite) begin
                  w_nextState  = MEMWAIT;
                  w_cntLoad    = 1'b1;
                  w_cntLoadVal = '0;
               end else if (bus.RegWrite) begin
                  w_nextState = WBACK;
               end else begin
                  w_nextState = FETCH;
                  w_pcWrite   = 1'b1;
                  w_pcSrcSel  = w_pcSelNow;
               end
            end
         end
         MEMWAIT: begin
            // An ack in the final wait cycle still completes the access
            if (bus.MemReady) begin
               if (bus.MemRead) begin
                  w_nextState = WBACK;
               end else begin
                  w_nextState = FETCH;
                  w_pcWrite   = 1'b1;
                  w_pcSrcSel  = r_pcSel;
               end
            end else if (w_cntCount == c_TIMEOUT_LAST) begin
               w_setMemErr = 1'b1;
               w_nextState = FETCH;
               w_pcWrite   = 1'b1;
               w_pcSrcSel  = r_pcSel;
            end else begin
               w_cntInc = 1'b1;
            end
         end
         WBACK: begin
            w_nextState = FETCH;
            w_pcWrite   = 1'b1;
            w_pcSrcSel  = r_pcSel;
         end
         STALL: begin
            if (w_cntZero) begin
               w_nextState = FETCH;
               w_pcWrite   = 1'b1;
            end else begin
               w_cntDec = 1'b1;
            end
         end
         HALT: begin
            if (bus.Resume) begin
               w_nextState = FETCH;
               w_pcWrite   = 1'b1;
            end
         end
         default: begin
            w_nextState = FETCH;
         end
      endcase
   end

   // IRWrite is qualified so every output reads 0 while reset is asserted
   assign bus.IRWrite    = rst_n && (r_state == FETCH);
   assign bus.AluStart   = w_aluStart;
   assign bus.MemReq     = (r_state == MEMWAIT);
   assign bus.RegWriteEn = (r_state == WBACK);
   assign bus.PCWrite    = w_pcWrite;
   assign bus.PCSrcSel   = w_pcSrcSel;
   assign bus.Halted     = (r_state == HALT);
   assign bus.MemErr     = r_memErr;
   assign bus.RetireCnt  = r_retireCnt;

endmodule
`default_nettype wire
